decoder_rr_arbiter: RTL and testbench
=====================================

# decoder_rr_arbiter

Round-robin arbiter and sequencer for the shared 3-to-8 decoder (74138-style: 3-bit select, G1/G2 enable pair, active-low outputs). Up to eight requesters share the decoder. The arbiter selects one requester at a time and drives the decoder's select and enable inputs. It enforces a one-cycle dead gap between consecutive grants so that two decoder outputs are never active in successive cycles without a disabled cycle between them. An optional hold timeout forces release from requesters that hold the grant too long.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive cycles one requester may hold a grant. Legal range is 1..255.
- `iClk` in 1: clock; all logic is on the rising edge.
- `iRst` in 1: synchronous reset, active-high.
- `iReq` in 8: level request, one bit per requester. Bit i requests decoder output i.
- `oSel` in/out: `oSel` out 3: decoder select (D2..D0); binary index of the granted requester.
- `oEna` out 2: decoder enable {G1,G2}. 2'b10 means enabled; 2'b01 means disabled.
- `oGnt` out 8: one-hot active-high grant; all zeros when no grant is active.
- `oValid` out 1: high while a grant is active.
- `oTimeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- **State machine:** three states, IDLE, GRANT and GAP.
- **Registers:** all outputs are registered. Internal state is the FSM state, a pointer `last[2:0]` and a counter `cnt[7:0]`.
- **Arbitration:** search `iReq` starting at index (last+1) mod 8 and wrap upward. The first set bit wins, and `last` is updated to the winner.
- **IDLE:**
  - Outputs: `oEna`=01, `oGnt`=0, `oValid`=0.
  - If any `iReq` bit is set, go to GRANT with the winner. `oSel`=winner, `oEna`=10, `oGnt`=1<<winner, `oValid`=1, `cnt`=1.
- **GRANT:** evaluated at each edge.
  - If `iReq[oSel]`=0: go to GAP (normal release).
  - Else if the timeout is compiled in and `cnt`==`MAX_HOLD`: go to GAP and set `oTimeout`=1 for that one cycle.
  - Else: stay in GRANT and increment `cnt`.
- **GAP:** lasts exactly one cycle.
  - Outputs: `oEna`=01, `oGnt`=0, `oValid`=0, `cnt`=0.
  - `oSel` holds its last value. Downstream logic must ignore `oSel` while `oEna`=01.
  - Next edge: if any `iReq` bit is set, arbitrate and go to GRANT. Otherwise go to IDLE.
- **Fairness after revocation:** a requester whose grant was released or revoked has the lowest priority at the next arbitration, because the search starts at last+1.
- **Simultaneous events:**
  - A request rising on the same edge as a GAP→GRANT arbitration is seen by that arbitration.
  - A release and a timeout on the same edge count as a normal release; `oTimeout` stays 0.
- **Invariants:**
  - `oGnt` is nonzero iff `oValid`=1, iff `oEna`=10.
  - When nonzero, `oGnt` has exactly one bit set, and that bit is bit `oSel`.

## Timing
- **Reset values (after the `iRst` edge):**
  - `oSel`=3'b000, `oEna`=2'b01, `oGnt`=8'h00, `oValid`=0, `oTimeout`=0.
  - state=IDLE, `last`=3'd7 (requester 0 has first priority), `cnt`=0.
- **Reset mid-operation:** `iRst` takes effect at the next edge from any state. The grant is dropped with no gap cycle and no `oTimeout` pulse.
- **Request-to-grant latency:** one cycle from IDLE. A request sampled at edge N shows `oValid`=1 after edge N.
- **Release latency:** `iReq[oSel]` sampled low at edge N gives `oEna`=01 after edge N.
- **Grant length:** with a timeout and continuous requests, each grant lasts exactly `MAX_HOLD` cycles. Each grant is followed by one gap cycle, so the grant period is `MAX_HOLD`+1 cycles.
- **Back-to-back requests:** the minimum spacing between the end of one grant and the start of the next is one cycle (the GAP). There is never a direct GRANT→GRANT transition.

## Configuration
- **Macro:** `DECODER_ARB_TIMEOUT_EN`.
- **Defined:** the `MAX_HOLD` comparison is active and `oTimeout` pulses as specified above.
- **Undefined:**
  - The timeout logic is removed and the grant is held for as long as `iReq[oSel]` stays high.
  - `oTimeout` is tied to 0.
  - `cnt` may be optimised away.
  - All other behaviour is unchanged.

## Test plan
- **Reset:** assert `iRst` for 2 cycles with `iReq`=8'hFF. Required: `oEna`=01, `oGnt`=00, `oValid`=0, `oSel`=0, `oTimeout`=0 during reset. After release, requester 0 is granted first.
- **Single request:** `iReq`=8'h04 for 5 cycles, then 8'h00.
  - Required during the grant: `oSel`=2, `oEna`=10, `oGnt`=8'h04 one cycle after the request, for 5 cycles.
  - Required after the request drops: one GAP cycle, then IDLE with `oEna`=01.
- **Full-load timeout (macro defined, `MAX_HOLD`=4):** `iReq`=8'hFF held.
  - Required: grants go to 0,1,2,...,7,0 in that order, each for 4 cycles.
  - Each grant is followed by one `oEna`=01 cycle, with `oTimeout` high in that cycle. The period is 5 cycles.
- **Wrap-around:** grant 6 and release it, then set `iReq`=8'h81 held with `MAX_HOLD`=2. Required: grant 7 first, then gap, then grant 0, then gap, then grant 7.
- **Reset mid-grant:** pulse `iRst` while requester 3 is granted. Required: all outputs return to reset values at the next edge with no `oTimeout` pulse. The next grant given `iReq`=8'h08 is requester 3.
- **Macro undefined:** `iReq`=8'hFF held for 300 cycles. Required: requester 0 is granted continuously and `oTimeout` stays 0 throughout.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 74138-style 3-to-8 decoder.
// Optional hold timeout is compiled in with `define DECODER_ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iReq,
  output logic [2:0] oSel,
  output logic [1:0] oEna,
  output logic [7:0] oGnt,
  output logic       oValid,
  output logic       oTimeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [1:0] EN_ON  = 2'b10;
  localparam logic [1:0] EN_OFF = 2'b01;

  localparam logic [7:0] LP_MAX = 8'(MAX_HOLD);

  logic [1:0] r_state;
  logic [2:0] r_last;
  logic [7:0] r_cnt;
  logic [2:0] r_sel;
  logic [1:0] r_ena;
  logic [7:0] r_gnt;
  logic       r_valid;
  logic       r_to;

  logic       w_any;
  logic [2:0] w_win;
  logic [2:0] w_idx;
  logic       w_rel;
  logic       w_hold_max;
  logic       w_to;

  // Rotating priority search: scan from last+1 upward, the
  // previous winner (offset 8 == offset 0) has lowest priority.
  always_comb begin
    w_any = |iReq;
    w_win = r_last;
    w_idx = '0;
    for (int k = 8; k >= 1; k--) begin
      w_idx = r_last + 3'(k);
      if (iReq[w_idx]) w_win = w_idx;
    end
  end

  assign w_rel      = ~iReq[r_sel];
  assign w_hold_max = (r_cnt == LP_MAX);

`ifdef DECODER_ARB_TIMEOUT_EN
  assign w_to = w_hold_max;
`else
  assign w_to = 1'b0;
`endif

  // Grant sequencer: IDLE -> GRANT -> GAP -> (GRANT | IDLE).
  // The counter saturates so it stays bounded without the timeout.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= S_IDLE;
      r_last  <= 3'd7;
      r_cnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_ena   <= EN_OFF;
      r_gnt   <= 8'h00;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_to <= 1'b0;
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_last  <= w_win;
            r_sel   <= w_win;
            r_ena   <= EN_ON;
            r_gnt   <= 8'h01 << w_win;
            r_valid <= 1'b1;
            r_cnt   <= 8'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (w_rel || w_to) begin
            r_state <= S_GAP;
            r_ena   <= EN_OFF;
            r_gnt   <= 8'h00;
            r_valid <= 1'b0;
            r_cnt   <= 8'd0;
            r_to    <= ~w_rel;
          end else if (!w_hold_max) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ena   <= EN_OFF;
          r_gnt   <= 8'h00;
          r_valid <= 1'b0;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign oSel     = r_sel;
  assign oEna     = r_ena;
  assign oGnt     = r_gnt;
  assign oValid   = r_valid;
  assign oTimeout = r_to;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter (default and timeout builds).
// Expected values are hand-derived from the arbiter behaviour.
module tb_decoder_rr_arbiter;

`ifdef DECODER_ARB_TIMEOUT_EN
  localparam int HOLD_N = 4;
`else
  localparam int HOLD_N = 5;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic [1:0] ena;
  logic [7:0] gnt;
  logic       vld;
  logic       tmo;

  int checks;
  int errors;

  decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
    .iClk     (clk),
    .iRst     (rst),
    .iReq     (req),
    .oSel     (sel),
    .oEna     (ena),
    .oGnt     (gnt),
    .oValid   (vld),
    .oTimeout (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] es,
                     input logic [1:0] ee, input logic [7:0] eg,
                     input logic ev, input logic et);
    logic [14:0] o;
    logic [14:0] e;
    o = {sel, ena, gnt, vld, tmo};
    e = {es, ee, eg, ev, et};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic on(input string tag, input logic [2:0] s);
    chk(tag, s, 2'b10, 8'h01 << s, 1'b1, 1'b0);
  endtask

  task automatic off(input string tag, input logic [2:0] s,
                     input logic t);
    chk(tag, s, 2'b01, 8'h00, 1'b0, t);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = 8'hFF;
    step(); off("rst1", 3'd0, 1'b0);
    step(); off("rst2", 3'd0, 1'b0);

    rst = 1'b0;
    step(); on("first_r0", 3'd0);
    req = 8'h00;
    step(); off("gap_r0", 3'd0, 1'b0);
    step(); off("idle_r0", 3'd0, 1'b0);

    req = 8'h04;
    for (int i = 0; i < HOLD_N; i++) begin
      step(); on("single_r2", 3'd2);
    end
    req = 8'h00;
    step(); off("single_gap", 3'd2, 1'b0);
    step(); off("single_idle", 3'd2, 1'b0);

    req = 8'h05;
    step(); on("fair_r0", 3'd0);
    req = 8'h04;
    step(); off("fair_gap", 3'd0, 1'b0);
    req = 8'h24;
    step(); on("fair_r2", 3'd2);
    req = 8'h20;
    step(); off("rise_gap", 3'd2, 1'b0);
    step(); on("rise_r5", 3'd5);
    req = 8'h00;
    step(); off("r5_gap", 3'd5, 1'b0);
    step(); off("r5_idle", 3'd5, 1'b0);

    req = 8'h40;
    step(); on("wrap_r6", 3'd6);
    req = 8'h00;
    step(); off("wrap_gap6", 3'd6, 1'b0);
    req = 8'h81;
    step(); on("wrap_r7", 3'd7);
    step(); on("wrap_r7b", 3'd7);
    step(); on("wrap_r7c", 3'd7);
    req = 8'h01;
    step(); off("wrap_gap7", 3'd7, 1'b0);
    req = 8'h81;
    step(); on("wrap_r0", 3'd0);
    req = 8'h80;
    step(); off("wrap_gap0", 3'd0, 1'b0);
    step(); on("wrap_r7_again", 3'd7);

    req = 8'h08;
    step(); off("mid_gap7", 3'd7, 1'b0);
    step(); on("mid_r3", 3'd3);
    rst = 1'b1;
    step(); off("mid_rst", 3'd0, 1'b0);
    rst = 1'b0;
    step(); on("mid_after_r3", 3'd3);

    rst = 1'b1;
    step(); off("load_rst", 3'd0, 1'b0);
    rst = 1'b0;
    req = 8'hFF;
`ifdef DECODER_ARB_TIMEOUT_EN
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        step(); on("load_grant", 3'(g));
      end
      step(); off("load_timeout_gap", 3'(g), 1'b1);
    end
`else
    for (int i = 0; i < 300; i++) begin
      step(); on("hold_r0", 3'd0);
    end
`endif
    req = 8'h00;
    step(); off("end_gap", 3'd0, 1'b0);
    step(); off("end_idle", 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
